snn_cfg_loader: RTL and testbench

Byte-stream configuration sequencer for the spiking neuron network's parameter register file. It accepts framed bursts of bytes over a valid/ready input. Each burst is decoded into auto-incrementing single-cycle writes on the network's `addr`/`data_in`/`write_enable` port. The block sits between the chip's host input pins and the network, and it asserts a hold signal so upstream logic can gate input spikes while parameters change.

---
 rtl/snn_cfg_loader.sv | 196 +++++++++++++++++++
 tb/tb_snn_cfg_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_cfg_loader.sv
// snn_cfg_loader: byte-stream configuration sequencer for the spiking network's
// parameter register file.
//
// A frame is a header byte ([7:4] start address, [3:0] N-1) followed by N payload
// bytes. Each payload byte becomes one write on cfg_addr/cfg_data/cfg_we. The
// address auto-increments and wraps from 14 to 0. Start address 15 is illegal, so
// that frame's payload is consumed and dropped. net_hold stays high while a burst
// is in flight so upstream logic can gate input spikes.
//
// Optional feature macro: SNN_CFG_CHECKSUM_EN
//   When defined, the payload is buffered and a checksum byte follows it. The burst
//   is replayed only when (header + payload + checksum) mod 256 == 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data, in_valid   input byte stream
//   in_ready            byte accepted on a rising edge where in_valid && in_ready
//   cfg_addr, cfg_data  register write address (0..14) and data
//   cfg_we              one-cycle write strobe
//   net_hold            burst in progress
//   done                pulses with the final write of a successful burst
//   err                 sticky error, cleared when the next header is accepted
module snn_cfg_loader #(
    parameter int unsigned BUF_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       cfg_we,
    output logic       net_hold,
    output logic       done,
    output logic       err
);

    if (BUF_DEPTH < 16) begin : g_depth_check
        $error("snn_cfg_loader: BUF_DEPTH must be at least 16");
    end

`ifdef SNN_CFG_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StData, StDiscard, StChk, StDrain} state_e;
`else
    typedef enum logic [1:0] {StIdle, StData, StDiscard} state_e;
`endif

    state_e     state_q;
    logic [3:0] addr_q;   // address of the next write
    logic [3:0] cnt_q;    // bytes (or writes) still to go, minus one
    logic       xfer;

    assign xfer = in_valid & in_ready;

    function automatic logic [3:0] next_addr(input logic [3:0] a);
        return (a == 4'd14) ? 4'd0 : a + 4'd1;
    endfunction

`ifdef SNN_CFG_CHECKSUM_EN
    localparam int unsigned IDX_W = $clog2(BUF_DEPTH);

    logic [7:0]       buf_q [BUF_DEPTH];
    logic [7:0]       sum_q;
    logic [7:0]       sum_next;
    logic [3:0]       n_q;     // N-1 of the current burst, for the replay
    logic [IDX_W-1:0] widx_q;
    logic [IDX_W-1:0] ridx_q;

    assign sum_next = sum_q + in_data;

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (state_q == StData && xfer) begin
            buf_q[widx_q] <= in_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= 4'd0;
            cnt_q    <= 4'd0;
            in_ready <= 1'b0;
            cfg_addr <= 4'd0;
            cfg_data <= 8'd0;
            cfg_we   <= 1'b0;
            net_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef SNN_CFG_CHECKSUM_EN
            sum_q    <= 8'd0;
            n_q      <= 4'd0;
            widx_q   <= '0;
            ridx_q   <= '0;
`endif
        end else begin
            cfg_we <= 1'b0;
            done   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    // Hold drops one cycle after the final write of the previous burst.
                    net_hold <= 1'b0;
                    if (xfer) begin
                        addr_q   <= in_data[7:4];
                        cnt_q    <= in_data[3:0];
                        net_hold <= 1'b1;
`ifdef SNN_CFG_CHECKSUM_EN
                        n_q      <= in_data[3:0];
                        sum_q    <= in_data;
                        widx_q   <= '0;
`endif
                        if (in_data[7:4] == 4'hF) begin
                            err     <= 1'b1;
                            state_q <= StDiscard;
                        end else begin
                            err     <= 1'b0;
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        cnt_q <= cnt_q - 4'd1;
`ifdef SNN_CFG_CHECKSUM_EN
                        sum_q  <= sum_next;
                        widx_q <= widx_q + 1'b1;
                        if (cnt_q == 4'd0) begin
                            state_q <= StChk;
                        end
`else
                        cfg_we   <= 1'b1;
                        cfg_addr <= addr_q;
                        cfg_data <= in_data;
                        addr_q   <= next_addr(addr_q);
                        if (cnt_q == 4'd0) begin
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end
`endif
                    end
                end
                StDiscard: begin
                    if (xfer) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd0) begin
                            net_hold <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                end
`ifdef SNN_CFG_CHECKSUM_EN
                StChk: begin
                    if (xfer) begin
                        if (sum_next == 8'd0) begin
                            // First replayed write leaves together with the checksum accept.
                            cfg_we   <= 1'b1;
                            cfg_addr <= addr_q;
                            cfg_data <= buf_q[0];
                            addr_q   <= next_addr(addr_q);
                            ridx_q   <= IDX_W'(1);
                            cnt_q    <= n_q;
                            done     <= (n_q == 4'd0);
                            in_ready <= 1'b0;
                            state_q  <= StDrain;
                        end else begin
                            err      <= 1'b1;
                            net_hold <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                end
                StDrain: begin
                    if (cnt_q == 4'd0) begin
                        in_ready <= 1'b1;
                        net_hold <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        cfg_we   <= 1'b1;
                        cfg_addr <= addr_q;
                        cfg_data <= buf_q[ridx_q];
                        addr_q   <= next_addr(addr_q);
                        ridx_q   <= ridx_q + 1'b1;
                        cnt_q    <= cnt_q - 4'd1;
                        done     <= (cnt_q == 4'd1);
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_cfg_loader.sv
// Self-checking bench for snn_cfg_loader: directed frames from the test plan plus
// random frames checked against a frame-level reference model (expected write list,
// error flag, hold window and write timing derived from the frame contents).
module tb_snn_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_we;
    logic       net_hold;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int addr;
        int data;
        int last;
        int cyc;
    } wr_t;

    wr_t        obs_q[$];
    bit         hold_hist[int];
    bit         rdy_hist[int];
    logic [7:0] pay_q[$];

    snn_cfg_loader #(.BUF_DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_we   (cfg_we),
        .net_hold (net_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        hold_hist[cyc] = net_hold;
        rdy_hist[cyc]  = in_ready;
        if (cfg_we) begin
            obs_q.push_back('{int'(cfg_addr), int'(cfg_data), int'(done), cyc});
            if (cfg_addr == 4'hF) chk("addr_15_seen", {28'd0, cfg_addr}, 32'd0);
        end
        if (done && !cfg_we) chk("done_without_we", {31'd0, cfg_we}, 32'd1);
    end

    // Present one byte and return the cycle stamp of its acceptance edge.
    task automatic send_byte(input logic [7:0] b, output int stamp);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            stamp = cyc;
        end else begin
            @(posedge clk);
            #1;
            stamp = cyc;
        end
        in_valid = 1'b0;
    endtask

    // Send header + pay_q (+ checksum when enabled). ck: -1 correct, -2 random wrong,
    // otherwise the literal checksum byte. Then compare against the frame model.
    task automatic run_frame(input logic [7:0] hdr, input int ck, input int gap);
        int  n, h, st, last, fall, c, a, sum;
        int  acc[$];
        wr_t exp_q[$];
        bit  exp_err, ok;
        n = int'(hdr[3:0]) + 1;
        obs_q.delete();
        send_byte(hdr, h);
        st = h;
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk);
            send_byte(pay_q[i], st);
            acc.push_back(st);
        end
        last = st;
        c = 0;
        exp_err = (hdr[7:4] == 4'hF);
        a = int'(hdr[7:4]);
        if (!exp_err) begin
`ifdef SNN_CFG_CHECKSUM_EN
            sum = int'(hdr);
            for (int i = 0; i < n; i++) sum += int'(pay_q[i]);
            if (ck == -1) ck = (256 - sum % 256) % 256;
            else if (ck == -2) ck = (256 - sum % 256 + int'($urandom_range(1, 255))) % 256;
            repeat (gap) @(negedge clk);
            send_byte(8'(ck), c);
            last = c;
            if ((sum + ck) % 256 != 0) begin
                exp_err = 1'b1;
            end else begin
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back('{a, int'(pay_q[i]), (i == n - 1) ? 1 : 0, c + i});
                    a = (a + 1) % 15;
                end
            end
`else
            sum = ck;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{a, int'(pay_q[i]), (i == n - 1) ? 1 : 0, acc[i]});
                a = (a + 1) % 15;
            end
`endif
        end
        fall = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1].cyc + 1 : last;
        while (cyc < fall + 2) @(negedge clk);

        chk("write_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk("write_addr", obs_q[i].addr, exp_q[i].addr);
            chk("write_data", obs_q[i].data, exp_q[i].data);
            chk("write_done", obs_q[i].last, exp_q[i].last);
            chk("write_cycle", obs_q[i].cyc, exp_q[i].cyc);
        end
        chk("err_flag", {31'd0, err}, {31'd0, exp_err});
        ok = 1'b1;
        for (int k = h; k < fall; k++) if (hold_hist[k] !== 1'b1) ok = 1'b0;
        chk("hold_window_high", {31'd0, ok}, 32'd1);
        chk("hold_fall", {31'd0, hold_hist[fall]}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_we", {31'd0, cfg_we}, 32'd0);
        if (exp_q.size() > 0) begin
            chk("addr_held", {28'd0, cfg_addr}, exp_q[exp_q.size() - 1].addr);
            chk("data_held", {24'd0, cfg_data}, exp_q[exp_q.size() - 1].data);
`ifdef SNN_CFG_CHECKSUM_EN
            ok = 1'b1;
            for (int k = c; k < c + n; k++) if (rdy_hist[k] !== 1'b0) ok = 1'b0;
            chk("drain_not_ready", {31'd0, ok}, 32'd1);
            chk("ready_after_drain", {31'd0, rdy_hist[c + n]}, 32'd1);
`endif
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, cfg_we}, 32'd0);
        chk({tag, "_addr"}, {28'd0, cfg_addr}, 32'd0);
        chk({tag, "_data"}, {24'd0, cfg_data}, 32'd0);
        chk({tag, "_hold"}, {31'd0, net_hold}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int st, nr, mode;
        logic [7:0] hdr;

        // Reset state
        #3;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Normal burst
        pay_q = {8'h80, 8'h10, 8'h02};
        run_frame(8'h02, -1, 0);

        // Address wrap 14 -> 0
        pay_q = {8'h11, 8'h22};
        run_frame(8'hE1, -1, 0);

        // Bad start address, then a good frame clears err
        pay_q = {8'h55};
        run_frame(8'hF0, -1, 0);
        pay_q = {8'h01};
        run_frame(8'h00, -1, 0);

`ifdef SNN_CFG_CHECKSUM_EN
        // Good and bad checksum
        pay_q = {8'h40};
        run_frame(8'h30, 8'h90, 0);
        run_frame(8'h30, 8'h91, 0);
`endif

        // Reset mid-burst
        send_byte(8'h02, st);
        send_byte(8'h11, st);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", {31'd0, in_ready}, 32'd1);
        pay_q = {8'hAB};
        run_frame(8'h40, -1, 0);

        // Stalled input
        pay_q = {8'hA5, 8'h5A};
        run_frame(8'h01, -1, 5);

        // Random frames
        for (int f = 0; f < 30; f++) begin
            hdr = 8'($urandom);
            nr = int'(hdr[3:0]) + 1;
            pay_q.delete();
            for (int i = 0; i < nr; i++) pay_q.push_back(8'($urandom));
            mode = ($urandom_range(0, 3) == 0) ? -2 : -1;
            run_frame(hdr, mode, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
